// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command sequencer: widths, ALU op codes,
// FSM state encoding and the response payload.
package alu_cmd_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned NREGS  = 4;
  localparam int unsigned REG_AW = 2;
  localparam int unsigned OP_W   = 3;

  // ALU select codes, forwarded unchanged to the ALU
  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [OP_W-1:0] ALU_NOT = 3'b101;
  localparam logic [OP_W-1:0] ALU_SHL = 3'b110;
  localparam logic [OP_W-1:0] ALU_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Response payload held while rsp_valid is high
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              zero;
  } rsp_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle of the ALU command sequencer.
//   cmd_*  : command request (valid/ready), load-immediate or ALU operation
//   rsp_*  : response (valid/ready) carrying written value and flags
// slave  = sequencer side, master = command issuer / response consumer.
interface alu_cmd_sequencer_if;
  import alu_cmd_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_load;
  logic [OP_W-1:0]   cmd_op;
  logic [REG_AW-1:0] cmd_dst;
  logic [REG_AW-1:0] cmd_srca;
  logic [REG_AW-1:0] cmd_srcb;
  logic [DATA_W-1:0] cmd_imm;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_carry;
  logic              rsp_zero;

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

endinterface

// File: rtl/alu_cmd_regfile.sv
// NREGS x DATA_W register file: two combinational operand read ports, one
// combinational debug read port, one synchronous write port, cleared on rst.
//   clk, rst            : clock, synchronous active-high reset
//   we, waddr, wdata    : write port
//   ra_addr/ra_data     : operand A read
//   rb_addr/rb_data     : operand B read
//   dbg_addr/dbg_data   : debug read
module alu_cmd_regfile
  import alu_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  // Storage: reset has priority over a same-edge write
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side master for a 4-bit combinational ALU. Accepts load/ALU
// commands, registers ALU operands and select, captures the ALU outputs one
// cycle later, writes the result back and returns result/flags.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : cmd_* request and rsp_* response handshakes
//   alu_a/alu_b/sel   : registered ALU inputs (hold outside EXEC)
//   alu_result/carry/zero : ALU outputs, sampled at the end of EXEC
//   dbg_addr/dbg_data : combinational register-file peek
module alu_cmd_sequencer
  import alu_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_cmd_sequencer_if.slave bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state_q, state_d;
  logic [REG_AW-1:0] dst_q;
  rsp_t              rsp_q, rsp_d;

  logic              alu_ld;
  logic              rsp_ld;
  logic              reg_we;
  logic [REG_AW-1:0] reg_waddr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] rd_a, rd_b;

  alu_cmd_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (reg_we),
    .waddr    (reg_waddr),
    .wdata    (reg_wdata),
    .ra_addr  (bus.cmd_srca),
    .ra_data  (rd_a),
    .rb_addr  (bus.cmd_srcb),
    .rb_data  (rd_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, write-port control and load enables
  always_comb begin
    state_d   = state_q;
    alu_ld    = 1'b0;
    rsp_ld    = 1'b0;
    rsp_d     = '0;
    reg_we    = 1'b0;
    reg_waddr = dst_q;
    reg_wdata = alu_result;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_load) begin
            // Immediate bypasses the ALU and answers next cycle
            reg_we       = 1'b1;
            reg_waddr    = bus.cmd_dst;
            reg_wdata    = bus.cmd_imm;
            rsp_ld       = 1'b1;
            rsp_d.result = bus.cmd_imm;
            rsp_d.carry  = 1'b0;
            rsp_d.zero   = (bus.cmd_imm == '0);
            state_d      = RESP;
          end else begin
            alu_ld  = 1'b1;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        // ALU has settled on the registered operands; capture and write back
        reg_we       = 1'b1;
        rsp_ld       = 1'b1;
        rsp_d.result = alu_result;
        rsp_d.carry  = alu_carry;
        rsp_d.zero   = alu_zero;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: ALU inputs, latched destination, response payload
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      dst_q   <= '0;
      rsp_q   <= '0;
    end else begin
      if (alu_ld) begin
        alu_a   <= rd_a;
        alu_b   <= rd_b;
        alu_sel <= bus.cmd_op;
        dst_q   <= bus.cmd_dst;
      end
      if (rsp_ld) begin
        rsp_q <= rsp_d;
      end
    end
  end

  // Ready must drop as soon as reset is raised, not an edge later
  assign bus.cmd_ready  = (state_q == IDLE) && !rst;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_result = rsp_q.result;
  assign bus.rsp_carry  = rsp_q.carry;
  assign bus.rsp_zero   = rsp_q.zero;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural 4-bit ALU sits beside the DUT,
// and an arithmetic reference model of the register file predicts every
// response, latency and debug readback.
module tb_alu_cmd_sequencer;
  import alu_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus ();

  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [OP_W-1:0]   alu_sel;
  logic              alu_carry, alu_zero;
  logic [REG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  int tests_run    = 0;
  int tests_failed = 0;
  int model_regs [NREGS];

  typedef struct { bit ld; int op; int dst; int sa; int sb; int imm; } tcmd_t;
  typedef struct { int lat; logic [3:0] res; logic car; logic zer; logic [3:0] dbg; } tobs_t;

  alu_cmd_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // The team's combinational ALU, modelled behaviourally
  always_comb begin
    alu_carry  = 1'b0;
    alu_result = '0;
    case (alu_sel)
      3'b000:  {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = ~alu_a;
      3'b110:  alu_result = {alu_a[2:0], 1'b0};
      default: alu_result = {1'b0, alu_a[3:1]};
    endcase
  end
  assign alu_zero = (alu_result == '0);

  function automatic tcmd_t mk(input bit ld, input int op, input int dst,
                               input int sa, input int sb, input int imm);
    tcmd_t c;
    c.ld = ld; c.op = op; c.dst = dst; c.sa = sa; c.sb = sb; c.imm = imm;
    return c;
  endfunction

  // Reference model: integer arithmetic on the register file contents
  function automatic void model_step(input tcmd_t c, output int r, output int cy,
                                     output int z, output int lat);
    int a, b;
    cy = 0;
    if (c.ld) begin
      r = c.imm; lat = 1;
    end else begin
      a = model_regs[c.sa]; b = model_regs[c.sb]; lat = 2;
      case (c.op)
        0: begin r = (a + b) % 16; cy = (a + b > 15) ? 1 : 0; end
        1: begin r = (a - b + 16) % 16; cy = (a < b) ? 1 : 0; end
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        5: r = 15 - a;
        6: r = (a * 2) % 16;
        default: r = a / 2;
      endcase
    end
    z = (r == 0) ? 1 : 0;
    model_regs[c.dst] = r;
  endfunction

  // Issue one command, wait for its response, optionally stall, then consume it
  task automatic run_cmd(input tcmd_t c, input int stall, output tobs_t o);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    bus.cmd_load  = c.ld;
    bus.cmd_op    = 3'(c.op);
    bus.cmd_dst   = REG_AW'(c.dst);
    bus.cmd_srca  = REG_AW'(c.sa);
    bus.cmd_srcb  = REG_AW'(c.sb);
    bus.cmd_imm   = 4'(c.imm);
    bus.cmd_valid = 1'b1;
    dbg_addr      = REG_AW'(c.dst);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    o.lat = 1;
    while (bus.rsp_valid !== 1'b1 && o.lat < 10) begin @(posedge clk); #1; o.lat++; end
    if (bus.rsp_valid !== 1'b1) o.lat = 99;
    o.dbg = dbg_data;
    repeat (stall) begin @(posedge clk); #1; end
    o.res = bus.rsp_result;
    o.car = bus.rsp_carry;
    o.zer = bus.rsp_zero;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_load = 1'b0; bus.cmd_op = '0; bus.cmd_dst = '0;
    bus.cmd_srca = '0; bus.cmd_srcb = '0; bus.cmd_imm = '0; bus.rsp_ready = 1'b0;
    dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hs: cmd_ready=%b rsp_valid=%b want 0/0", bus.cmd_ready, bus.rsp_valid);
    end
    tests_run++;
    if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_sel !== 3'b000 ||
        bus.rsp_result !== 4'h0 || bus.rsp_carry !== 1'b0 || bus.rsp_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_regs: a=%h b=%h sel=%b rsp=%h/%b/%b want all 0",
               alu_a, alu_b, alu_sel, bus.rsp_result, bus.rsp_carry, bus.rsp_zero);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = REG_AW'(i); #1;
      tests_run++;
      if (dbg_data !== 4'h0) begin
        tests_failed++;
        $display("FAIL reset_dbg[%0d]: got %h want 0", i, dbg_data);
      end
      model_regs[i] = 0;
    end
    rst = 1'b0; #1;
    tests_run++;
    if (bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: cmd_ready=%b want 1", bus.cmd_ready);
    end
  endtask

  // Runs a command list; each response checked against the model, last one against spec constants
  task automatic run_list(input string name, input tcmd_t q[$], input int want_r,
                          input int want_c, input int want_z);
    tobs_t o;
    int er, ec, ez, el;
    foreach (q[i]) begin
      run_cmd(q[i], 0, o);
      model_step(q[i], er, ec, ez, el);
      tests_run++;
      if (o.res !== 4'(er) || o.car !== 1'(ec) || o.zer !== 1'(ez)) begin
        tests_failed++;
        $display("FAIL %s[%0d] rsp: got %h/%b/%b want %h/%0d/%0d", name, i, o.res, o.car, o.zer, er, ec, ez);
      end
      tests_run++;
      if (o.lat != el) begin
        tests_failed++;
        $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, o.lat, el);
      end
      tests_run++;
      if (o.dbg !== 4'(er)) begin
        tests_failed++;
        $display("FAIL %s[%0d] dbg: got %h want %h", name, i, o.dbg, er);
      end
    end
    tests_run++;
    if (o.res !== 4'(want_r) || o.car !== 1'(want_c) || o.zer !== 1'(want_z)) begin
      tests_failed++;
      $display("FAIL %s final: got %h/%b/%b want %h/%0d/%0d", name, o.res, o.car, o.zer, want_r, want_c, want_z);
    end
  endtask

  task automatic test_add();
    tcmd_t q[$];
    q.push_back(mk(1, 0, 0, 0, 0, 5));
    q.push_back(mk(1, 0, 1, 0, 0, 3));
    q.push_back(mk(0, int'(ALU_ADD), 2, 0, 1, 0));
    run_list("add", q, 8, 0, 0);
  endtask

  task automatic test_carry();
    tcmd_t q[$];
    q.push_back(mk(1, 0, 0, 0, 0, 15));
    q.push_back(mk(1, 0, 1, 0, 0, 1));
    q.push_back(mk(0, int'(ALU_ADD), 3, 0, 1, 0));
    run_list("carry", q, 0, 1, 1);
  endtask

  task automatic test_sub_forward();
    tcmd_t q[$];
    q.push_back(mk(1, 0, 0, 0, 0, 3));
    q.push_back(mk(1, 0, 1, 0, 0, 5));
    q.push_back(mk(0, int'(ALU_SUB), 0, 0, 1, 0));
    run_list("sub", q, 14, 1, 0);
    q.delete();
    q.push_back(mk(0, int'(ALU_ADD), 2, 0, 1, 0));
    run_list("fwd", q, 3, 1, 0);
  endtask

  task automatic test_and_shl();
    tcmd_t q[$];
    q.push_back(mk(1, 0, 0, 0, 0, 10));
    q.push_back(mk(1, 0, 1, 0, 0, 5));
    q.push_back(mk(0, int'(ALU_AND), 2, 0, 1, 0));
    run_list("and", q, 0, 0, 1);
    q.delete();
    q.push_back(mk(0, int'(ALU_SHL), 3, 0, 1, 0));
    run_list("shl", q, 4, 0, 0);
    q.delete();
    q.push_back(mk(1, 0, 1, 0, 0, 7));
    run_list("ld", q, 7, 0, 0);
    tests_run++;
    if (alu_a !== 4'hA || alu_b !== 4'h5 || alu_sel !== ALU_SHL) begin
      tests_failed++;
      $display("FAIL alu_hold: a=%h b=%h sel=%b want a/5/110", alu_a, alu_b, alu_sel);
    end
  endtask

  task automatic test_backpressure();
    tcmd_t q[$];
    tcmd_t c;
    int er, ec, ez, el;
    q.push_back(mk(1, 0, 0, 0, 0, 2));
    q.push_back(mk(1, 0, 1, 0, 0, 2));
    q.push_back(mk(1, 0, 3, 0, 0, 6));
    run_list("bp_ld", q, 6, 0, 0);
    c = mk(0, int'(ALU_ADD), 2, 0, 1, 0);
    bus.cmd_load = 1'b0; bus.cmd_op = ALU_ADD; bus.cmd_dst = 2'd2;
    bus.cmd_srca = 2'd0; bus.cmd_srcb = 2'd1; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    model_step(c, er, ec, ez, el);
    for (int i = 0; i < 4; i++) begin
      // pulse a load to r3 while the response is stalled; it must be ignored
      if (i == 1) begin
        bus.cmd_load = 1'b1; bus.cmd_dst = 2'd3; bus.cmd_imm = 4'h9; bus.cmd_valid = 1'b1;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      #1;
      tests_run++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 4'h4 || bus.cmd_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: valid=%b result=%h cmd_ready=%b want 1/4/0",
                 i, bus.rsp_valid, bus.rsp_result, bus.cmd_ready);
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: valid=%b cmd_ready=%b want 0/1", bus.rsp_valid, bus.cmd_ready);
    end
    dbg_addr = 2'd3; #1;
    tests_run++;
    if (dbg_data !== 4'(model_regs[3])) begin
      tests_failed++;
      $display("FAIL bp_ignored: r3=%h want %h", dbg_data, model_regs[3]);
    end
    dbg_addr = 2'd2; #1;
    tests_run++;
    if (dbg_data !== 4'(er)) begin
      tests_failed++;
      $display("FAIL bp_wb: r2=%h want %h", dbg_data, er);
    end
  endtask

  task automatic test_reset_mid();
    tcmd_t q[$];
    q.push_back(mk(1, 0, 0, 0, 0, 9));
    q.push_back(mk(1, 0, 1, 0, 0, 4));
    run_list("rm_ld", q, 4, 0, 0);
    bus.cmd_load = 1'b0; bus.cmd_op = ALU_ADD; bus.cmd_dst = 2'd1;
    bus.cmd_srca = 2'd0; bus.cmd_srcb = 2'd1; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rm_abort: valid=%b cmd_ready=%b want 0/0", bus.rsp_valid, bus.cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = REG_AW'(i); #0.5;
      tests_run++;
      if (dbg_data !== 4'h0) begin
        tests_failed++;
        $display("FAIL rm_dbg[%0d]: got %h want 0", i, dbg_data);
      end
      model_regs[i] = 0;
    end
    rst = 1'b0; #1;
    tests_run++;
    if (bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rm_ready: cmd_ready=%b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_random();
    tcmd_t c;
    tobs_t o;
    int er, ec, ez, el;
    for (int i = 0; i < 40; i++) begin
      c = mk(($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      if (i < 4) c = mk(1, 0, i, 0, 0, int'($urandom_range(0, 15)));
      run_cmd(c, int'($urandom_range(0, 2)), o);
      model_step(c, er, ec, ez, el);
      tests_run++;
      if (o.res !== 4'(er) || o.car !== 1'(ec) || o.zer !== 1'(ez) || o.lat != el) begin
        tests_failed++;
        $display("FAIL rand[%0d] ld=%0d op=%0d: got %h/%b/%b lat %0d want %h/%0d/%0d lat %0d",
                 i, c.ld, c.op, o.res, o.car, o.zer, o.lat, er, ec, ez, el);
      end
      tests_run++;
      if (o.dbg !== 4'(er)) begin
        tests_failed++;
        $display("FAIL rand[%0d] dbg: got %h want %h", i, o.dbg, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_sub_forward();
    test_and_shl();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-side master for the team's 4-bit combinational ALU (a, b, sel in; result, carry, zero out).
- Accepts register-level commands over a valid/ready port and holds a small register file.
- Drives the ALU operand and select inputs, captures the ALU outputs, writes the result back, and returns result/flags over a valid/ready response port.
- Turns the bare ALU into a sequenced execution unit for the datapath.

Parameters:
DATA_W, 4, operand/result width; must match the ALU width.
NREGS, 4, register-file depth.
REG_AW, 2, register address width, log2(NREGS).

Ports:
clk  in  1  system clock; all logic rising-edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
cmd_load  in  1  1 = load immediate into cmd_dst; 0 = ALU operation.
cmd_op  in  3  ALU select code, passed unchanged to alu_sel.
cmd_dst  in  REG_AW  destination register.
cmd_srca  in  REG_AW  operand A register.
cmd_srcb  in  REG_AW  operand B register.
cmd_imm  in  DATA_W  immediate, used when cmd_load=1.
alu_a  out  DATA_W  registered ALU operand A.
alu_b  out  DATA_W  registered ALU operand B.
alu_sel  out  3  registered ALU operation select.
alu_result  in  DATA_W  ALU result.
alu_carry  in  1  ALU carry/borrow.
alu_zero  in  1  ALU zero flag.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer takes the response.
rsp_result  out  DATA_W  value written to cmd_dst.
rsp_carry  out  1  captured carry.
rsp_zero  out  1  captured zero.
dbg_addr  in  REG_AW  debug read address.
dbg_data  out  DATA_W  combinational read of regfile[dbg_addr].

Behaviour:
Reset (synchronous, active-high):
- State returns to IDLE.
- All registers, alu_a/alu_b/alu_sel, and rsp_result/rsp_carry/rsp_zero go to 0; rsp_valid goes to 0.
- cmd_ready = 0 while rst is high.

FSM states IDLE, EXEC, RESP:
- IDLE: cmd_ready = 1. Accept on cmd_valid & cmd_ready at edge N.
  - cmd_load=0: at edge N, alu_a <= reg[srca], alu_b <= reg[srcb], alu_sel <= cmd_op; latch cmd_dst; go to EXEC.
  - cmd_load=1: at edge N, reg[dst] <= cmd_imm, rsp_result <= cmd_imm, rsp_carry <= 0, rsp_zero <= (cmd_imm==0); go to RESP. The ALU is not used.
- EXEC (exactly one cycle): the ALU settles combinationally on the registered inputs. At edge N+1: rsp_result/rsp_carry/rsp_zero <= alu_result/alu_carry/alu_zero, reg[dst] <= alu_result; go to RESP.
- RESP: rsp_valid = 1; response fields held stable. On rsp_ready go to IDLE. cmd_ready = 0 in EXEC and RESP.

Latency and throughput:
- ALU op: rsp_valid is high in the cycle after EXEC, i.e. 2 edges after accept.
- Load: rsp_valid is high 1 edge after accept.
- Minimum spacing: ALU op 3 cycles, load 2 cycles.

Arithmetic and register rules:
- Flags are stored exactly as the ALU reports them; no reinterpretation.
- Carry is meaningful only for codes 000/001; the ALU forces it to 0 otherwise.
- dst may equal srca or srcb; operands are read at accept, before writeback.
- The next command always reads the updated register, because acceptance occurs only in IDLE.

Boundary conditions:
- Holding: alu_* outputs hold their last values outside EXEC.
- Back-pressure: rsp_ready held low keeps RESP indefinitely with all outputs stable; cmd_valid is ignored.
- Command stability: cmd_valid without cmd_ready leaves state unchanged; the command is not latched.
- Reset mid-operation: rst in EXEC or RESP aborts with no writeback, and rsp_valid is 0 in the next cycle.
- Debug port: dbg_data reflects a write on the cycle after the writing edge.

Decomposition:
- Package alu_cmd_pkg:
  - op-code constants ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_XOR=100, ALU_NOT=101, ALU_SHL=110, ALU_SHR=111;
  - state encoding IDLE/EXEC/RESP;
  - DATA_W/REG_AW defaults.
- One sub-module, alu_cmd_regfile: NREGS x DATA_W, two combinational read ports plus the debug read port, one synchronous write port, cleared on rst.
- The ALU is instantiated beside this block, not inside it.

Test Plan:
- Load r0=5, r1=3; ADD dst=r2 (srca=r0, srcb=r1) -> rsp 8, carry 0, zero 0, rsp_valid 2 edges after accept; dbg r2=8.
- Load r0=F, r1=1; ADD dst=r3 -> rsp 0, carry 1, zero 1; dbg r3=0.
- r0=3, r1=5; SUB dst=r0 (srca=r0) -> rsp E, carry 1, zero 0; next ADD dst=r2 (srca=r0, srcb=r1) -> rsp 3, carry 1, zero 0, confirming r0=E was read.
- r0=A, r1=5; AND -> rsp 0, zero 1, carry 0. Then SHL of r0=A -> rsp 4, carry 0.
- Hold rsp_ready=0 for 4 cycles after ADD 2+2 -> rsp_valid=1 and rsp_result=4 stable; cmd_ready=0; a pulsed cmd_valid is not accepted.
- Assert rst during EXEC of an ADD with dst=r1 -> rsp_valid=0 next cycle; dbg_data=0 for every address; cmd_ready=1 the cycle after rst falls.
